program_runner: RTL and testbench

Executes a 26-bit wash-program word (as produced by the program-selection logic) phase by phase. It counts down each timed field on an external time-unit tick, skips zero-length phases, and drives valve/motor controls. It returns the live remaining-program word in the same 26-bit layout, so the display path can show it unchanged. It sits between program selection and the actuator/display outputs.

---
 rtl/wash_pkg.sv | 98 +++++++++
 rtl/next_phase.sv | 30 +++
 rtl/program_runner.sv | 144 ++++++++++++++
 tb/tb_program_runner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared field layout, phase codes, FSM encoding and actuator map
//
// Purpose: single source of truth for the 26-bit wash-program word layout.
// Contents:
//   state_t              FSM state encoding
//   PH_*                 phase codes (field index 0..7)
//   F_*_MSB / F_*_LSB    bit offsets of each field, F_*_W widths
//   ACT_*                actuator patterns {fill, drain, slow, fast}
//   field_get/field_dec  read / decrement one field selected by phase code
//   field_sum            sum of all eight fields
//   phase_act            phase code -> actuator pattern
package wash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_ERROR = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int WORD_W   = 26;
   localparam int N_FIELDS = 8;

   localparam logic [2:0] PH_W_FILL  = 3'd0;
   localparam logic [2:0] PH_W_WASH  = 3'd1;
   localparam logic [2:0] PH_R_DRAIN = 3'd2;
   localparam logic [2:0] PH_R_SPIN  = 3'd3;
   localparam logic [2:0] PH_R_FILL  = 3'd4;
   localparam logic [2:0] PH_R_RINSE = 3'd5;
   localparam logic [2:0] PH_D_DRAIN = 3'd6;
   localparam logic [2:0] PH_D_SPIN  = 3'd7;

   localparam int F_W_FILL_MSB  = 25, F_W_FILL_LSB  = 23, F_W_FILL_W  = 3;
   localparam int F_W_WASH_MSB  = 22, F_W_WASH_LSB  = 19, F_W_WASH_W  = 4;
   localparam int F_R_DRAIN_MSB = 18, F_R_DRAIN_LSB = 16, F_R_DRAIN_W = 3;
   localparam int F_R_SPIN_MSB  = 15, F_R_SPIN_LSB  = 13, F_R_SPIN_W  = 3;
   localparam int F_R_FILL_MSB  = 12, F_R_FILL_LSB  = 10, F_R_FILL_W  = 3;
   localparam int F_R_RINSE_MSB = 9,  F_R_RINSE_LSB = 6,  F_R_RINSE_W = 4;
   localparam int F_D_DRAIN_MSB = 5,  F_D_DRAIN_LSB = 3,  F_D_DRAIN_W = 3;
   localparam int F_D_SPIN_MSB  = 2,  F_D_SPIN_LSB  = 0,  F_D_SPIN_W  = 3;

   // Actuator pattern bit order: {fill_valve, drain_valve, motor_slow, motor_fast}
   localparam logic [3:0] ACT_NONE  = 4'b0000;
   localparam logic [3:0] ACT_FILL  = 4'b1000;
   localparam logic [3:0] ACT_DRAIN = 4'b0100;
   localparam logic [3:0] ACT_WASH  = 4'b0010;
   localparam logic [3:0] ACT_SPIN  = 4'b0101;

   // 3-bit fields are returned zero-extended to 4 bits.
   function automatic logic [3:0] field_get(input logic [WORD_W-1:0] w, input logic [2:0] idx);
      case (idx)
         PH_W_FILL:  return {1'b0, w[F_W_FILL_MSB:F_W_FILL_LSB]};
         PH_W_WASH:  return w[F_W_WASH_MSB:F_W_WASH_LSB];
         PH_R_DRAIN: return {1'b0, w[F_R_DRAIN_MSB:F_R_DRAIN_LSB]};
         PH_R_SPIN:  return {1'b0, w[F_R_SPIN_MSB:F_R_SPIN_LSB]};
         PH_R_FILL:  return {1'b0, w[F_R_FILL_MSB:F_R_FILL_LSB]};
         PH_R_RINSE: return w[F_R_RINSE_MSB:F_R_RINSE_LSB];
         PH_D_DRAIN: return {1'b0, w[F_D_DRAIN_MSB:F_D_DRAIN_LSB]};
         default:    return {1'b0, w[F_D_SPIN_MSB:F_D_SPIN_LSB]};
      endcase
   endfunction

   // Caller guarantees the selected field is nonzero.
   function automatic logic [WORD_W-1:0] field_dec(input logic [WORD_W-1:0] w, input logic [2:0] idx);
      logic [WORD_W-1:0] r;
      r = w;
      case (idx)
         PH_W_FILL:  r[F_W_FILL_MSB:F_W_FILL_LSB]   = w[F_W_FILL_MSB:F_W_FILL_LSB] - 3'd1;
         PH_W_WASH:  r[F_W_WASH_MSB:F_W_WASH_LSB]   = w[F_W_WASH_MSB:F_W_WASH_LSB] - 4'd1;
         PH_R_DRAIN: r[F_R_DRAIN_MSB:F_R_DRAIN_LSB] = w[F_R_DRAIN_MSB:F_R_DRAIN_LSB] - 3'd1;
         PH_R_SPIN:  r[F_R_SPIN_MSB:F_R_SPIN_LSB]   = w[F_R_SPIN_MSB:F_R_SPIN_LSB] - 3'd1;
         PH_R_FILL:  r[F_R_FILL_MSB:F_R_FILL_LSB]   = w[F_R_FILL_MSB:F_R_FILL_LSB] - 3'd1;
         PH_R_RINSE: r[F_R_RINSE_MSB:F_R_RINSE_LSB] = w[F_R_RINSE_MSB:F_R_RINSE_LSB] - 4'd1;
         PH_D_DRAIN: r[F_D_DRAIN_MSB:F_D_DRAIN_LSB] = w[F_D_DRAIN_MSB:F_D_DRAIN_LSB] - 3'd1;
         default:    r[F_D_SPIN_MSB:F_D_SPIN_LSB]   = w[F_D_SPIN_MSB:F_D_SPIN_LSB] - 3'd1;
      endcase
      return r;
   endfunction

   function automatic logic [6:0] field_sum(input logic [WORD_W-1:0] w);
      logic [6:0] s;
      s = 7'd0;
      for (int i = 0; i < N_FIELDS; i++)
         s = s + {3'b000, field_get(w, 3'(i))};
      return s;
   endfunction

   function automatic logic [3:0] phase_act(input logic [2:0] ph);
      case (ph)
         PH_W_FILL, PH_R_FILL:   return ACT_FILL;
         PH_W_WASH, PH_R_RINSE:  return ACT_WASH;
         PH_R_DRAIN, PH_D_DRAIN: return ACT_DRAIN;
         default:                return ACT_SPIN;
      endcase
   endfunction

endpackage

// File: rtl/next_phase.sv
// rtl/next_phase.sv - priority search for the next nonzero program field
//
// Purpose: returns the lowest field index >= from_idx whose field is nonzero.
// Ports:
//   word      in  26  program word to search
//   from_idx  in  4   first index considered (8 means "past the end")
//   idx       out 3   lowest matching field index (0 when none)
//   none      out 1   no nonzero field at or above from_idx
module next_phase
   import wash_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [3:0]        from_idx,
   output logic [2:0]        idx,
   output logic              none
);

   // Scanning downward lets the lowest qualifying index win.
   always_comb begin
      idx  = 3'd0;
      none = 1'b1;
      for (int i = N_FIELDS - 1; i >= 0; i--) begin
         if (4'(i) >= from_idx && field_get(word, 3'(i)) != 4'd0) begin
            idx  = 3'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/program_runner.sv
// rtl/program_runner.sv - executes a wash-program word phase by phase
//
// Purpose: counts each timed field down on tick, skips empty phases and drives
// the actuators; remaining keeps the program word layout for the display.
// Ports:
//   cp, reset                       clock, synchronous active-high reset
//   start, pause, tick, door_open   control inputs
//   program_word                    26-bit program, sampled on accepted start
//   remaining, phase, total_left    live program state
//   fill_valve, drain_valve,
//   motor_slow, motor_fast          actuator enables (RUN only)
//   busy, paused, error, done       status flags (done is a one-cycle pulse)
module program_runner
   import wash_pkg::*;
(
   input  logic              cp,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              tick,
   input  logic              door_open,
   input  logic [WORD_W-1:0] program_word,
   output logic [WORD_W-1:0] remaining,
   output logic [2:0]        phase,
   output logic [6:0]        total_left,
   output logic              fill_valve,
   output logic              drain_valve,
   output logic              motor_slow,
   output logic              motor_fast,
   output logic              busy,
   output logic              paused,
   output logic              error,
   output logic              done
);

   state_t            state, state_nx;
   logic [WORD_W-1:0] rem_nx, dec_word, search_word;
   logic [2:0]        phase_nx, np_idx;
   logic [6:0]        total_nx;
   logic [3:0]        cur_field, search_from, act_nx;
   logic              np_none;
   logic              busy_nx, paused_nx, error_nx, done_nx;

   assign cur_field = field_get(remaining, phase);
   assign dec_word  = field_dec(remaining, phase);

   // One search instance serves both load (whole new word from index 0) and
   // advance (decremented word, strictly after the current phase).
   assign search_word = (state == ST_IDLE) ? program_word : dec_word;
   assign search_from = (state == ST_IDLE) ? 4'd0 : ({1'b0, phase} + 4'd1);

   next_phase u_next_phase (
      .word     (search_word),
      .from_idx (search_from),
      .idx      (np_idx),
      .none     (np_none)
   );

   always_ff @(posedge cp) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rem_nx   = remaining;
      phase_nx = phase;
      total_nx = total_left;
      case (state)
         ST_IDLE: begin
            if (start && program_word != '0) begin
               state_nx = ST_RUN;
               rem_nx   = program_word;
               total_nx = field_sum(program_word);
               phase_nx = np_idx;
            end
         end
         ST_RUN: begin
            if (door_open)
               state_nx = ST_ERROR;
            else if (pause)
               state_nx = ST_PAUSE;
            else if (tick && cur_field != 4'd0) begin
               rem_nx   = dec_word;
               total_nx = total_left - 7'd1;
               if (cur_field == 4'd1) begin
                  if (np_none) begin
                     state_nx = ST_DONE;
                     rem_nx   = '0;
                     total_nx = 7'd0;
                     phase_nx = 3'd0;
                  end else begin
                     phase_nx = np_idx;
                  end
               end
            end
         end
         ST_PAUSE: begin
            if (door_open)  state_nx = ST_ERROR;
            else if (pause) state_nx = ST_RUN;
         end
         ST_ERROR: begin
            if (pause && !door_open) state_nx = ST_PAUSE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up
   // with the state they describe.
   always_comb begin
      act_nx    = (state_nx == ST_RUN) ? phase_act(phase_nx) : ACT_NONE;
      busy_nx   = (state_nx == ST_RUN) || (state_nx == ST_PAUSE) || (state_nx == ST_ERROR);
      paused_nx = (state_nx == ST_PAUSE);
      error_nx  = (state_nx == ST_ERROR);
      done_nx   = (state_nx == ST_DONE);
   end

   always_ff @(posedge cp) begin
      if (reset) begin
         remaining   <= '0;
         phase       <= 3'd0;
         total_left  <= 7'd0;
         fill_valve  <= 1'b0;
         drain_valve <= 1'b0;
         motor_slow  <= 1'b0;
         motor_fast  <= 1'b0;
         busy        <= 1'b0;
         paused      <= 1'b0;
         error       <= 1'b0;
         done        <= 1'b0;
      end else begin
         remaining   <= rem_nx;
         phase       <= phase_nx;
         total_left  <= total_nx;
         {fill_valve, drain_valve, motor_slow, motor_fast} <= act_nx;
         busy        <= busy_nx;
         paused      <= paused_nx;
         error       <= error_nx;
         done        <= done_nx;
      end
   end

endmodule

// File: tb/tb_program_runner.sv
// tb/tb_program_runner.sv - scoreboard bench for program_runner
module tb_program_runner;

   typedef struct packed {
      logic [2:0]  ph;
      logic [25:0] rem;
      logic [6:0]  tot;
      logic [3:0]  act;
      logic        busy;
      logic        paused;
      logic        err;
      logic        done;
   } obs_t;

   logic        cp = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        tick = 1'b0;
   logic        door_open = 1'b0;
   logic [25:0] prog = '0;
   logic [25:0] remaining;
   logic [2:0]  phase;
   logic [6:0]  total_left;
   logic        fill_valve, drain_valve, motor_slow, motor_fast;
   logic        busy, paused, error, done;

   obs_t  exp_q[$];
   int    due_q[$];
   string name_q[$];
   int    cyc_n = 0;
   int    n_checks = 0;
   int    n_pass = 0;

   localparam logic [25:0] P1 = 26'b011_1010_100_101_011_1000_100_101;
   localparam logic [25:0] P2 = 26'b000_0000_000_000_000_0000_100_101;

   program_runner dut (
      .cp           (cp),
      .reset        (reset),
      .start        (start),
      .pause        (pause),
      .tick         (tick),
      .door_open    (door_open),
      .program_word (prog),
      .remaining    (remaining),
      .phase        (phase),
      .total_left   (total_left),
      .fill_valve   (fill_valve),
      .drain_valve  (drain_valve),
      .motor_slow   (motor_slow),
      .motor_fast   (motor_fast),
      .busy         (busy),
      .paused       (paused),
      .error        (error),
      .done         (done)
   );

   always #5 cp = ~cp;

   always @(posedge cp) cyc_n <= cyc_n + 1;

   // Monitor: pops every expectation whose edge has occurred and compares.
   always @(negedge cp) begin
      obs_t got, want;
      string nm;
      got = '{phase, remaining, total_left,
              {fill_valve, drain_valve, motor_slow, motor_fast},
              busy, paused, error, done};
      while (exp_q.size() > 0 && due_q[0] <= cyc_n) begin
         want = exp_q.pop_front();
         void'(due_q.pop_front());
         nm = name_q.pop_front();
         n_checks++;
         if (got === want)
            n_pass++;
         else
            $display("FAIL %s: got ph=%0d rem=%b tot=%0d act=%b bped=%b%b%b%b, want ph=%0d rem=%b tot=%0d act=%b bped=%b%b%b%b",
                     nm, got.ph, got.rem, got.tot, got.act, got.busy, got.paused, got.err, got.done,
                     want.ph, want.rem, want.tot, want.act, want.busy, want.paused, want.err, want.done);
      end
   end

   task automatic cyc(input logic st, input logic pa, input logic tk, input logic [25:0] pw);
      start = st;
      pause = pa;
      tick  = tk;
      prog  = pw;
      @(posedge cp);
      #1;
      start = 1'b0;
      pause = 1'b0;
      tick  = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, '0);
   endtask

   task automatic expect_obs(input string nm, input logic [2:0] ph, input logic [25:0] rem,
                             input logic [6:0] tot, input logic [3:0] act,
                             input logic b, input logic p, input logic e, input logic d);
      exp_q.push_back('{ph, rem, tot, act, b, p, e, d});
      due_q.push_back(cyc_n);
      name_q.push_back(nm);
   endtask

   localparam logic [25:0] W39 = 26'b000_1010_100_101_011_1000_100_101;
   localparam logic [25:0] W38 = 26'b000_1001_100_101_011_1000_100_101;

   initial begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0);
      expect_obs("reset_state", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);
      reset = 1'b0;

      // Program 1: full run with pause / door interruptions
      cyc(1'b1, 1'b0, 1'b0, P1);
      expect_obs("load1", 3'd0, P1, 7'd42, 4'b1000, 1, 0, 0, 0);
      ticks(1);
      expect_obs("tick1", 3'd0, 26'b010_1010_100_101_011_1000_100_101, 7'd41, 4'b1000, 1, 0, 0, 0);
      ticks(2);
      expect_obs("to_wash", 3'd1, W39, 7'd39, 4'b0010, 1, 0, 0, 0);
      ticks(1);
      expect_obs("wash_dec", 3'd1, W38, 7'd38, 4'b0010, 1, 0, 0, 0);
      cyc(1'b0, 1'b1, 1'b1, '0);
      expect_obs("pause_tick", 3'd1, W38, 7'd38, 4'b0000, 1, 1, 0, 0);
      ticks(5);
      expect_obs("paused_ticks", 3'd1, W38, 7'd38, 4'b0000, 1, 1, 0, 0);
      cyc(1'b0, 1'b1, 1'b0, '0);
      expect_obs("resume", 3'd1, W38, 7'd38, 4'b0010, 1, 0, 0, 0);
      door_open = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, '0);
      expect_obs("door_err", 3'd1, W38, 7'd38, 4'b0000, 1, 0, 1, 0);
      cyc(1'b0, 1'b1, 1'b0, '0);
      expect_obs("err_door_held", 3'd1, W38, 7'd38, 4'b0000, 1, 0, 1, 0);
      door_open = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, '0);
      expect_obs("err_closed", 3'd1, W38, 7'd38, 4'b0000, 1, 0, 1, 0);
      cyc(1'b0, 1'b1, 1'b0, '0);
      expect_obs("err_to_pause", 3'd1, W38, 7'd38, 4'b0000, 1, 1, 0, 0);
      cyc(1'b0, 1'b1, 1'b0, '0);
      expect_obs("pause_to_run", 3'd1, W38, 7'd38, 4'b0010, 1, 0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0, P2);
      expect_obs("start_in_run", 3'd1, W38, 7'd38, 4'b0010, 1, 0, 0, 0);
      ticks(9);
      expect_obs("r_drain", 3'd2, 26'b000_0000_100_101_011_1000_100_101, 7'd29, 4'b0100, 1, 0, 0, 0);
      ticks(4);
      expect_obs("r_spin", 3'd3, 26'b000_0000_000_101_011_1000_100_101, 7'd25, 4'b0101, 1, 0, 0, 0);
      ticks(24);
      expect_obs("last_unit", 3'd7, 26'd1, 7'd1, 4'b0101, 1, 0, 0, 0);
      ticks(1);
      expect_obs("done1", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 1);
      cyc(1'b0, 1'b0, 1'b0, '0);
      expect_obs("idle1", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);

      // Program 2: load skips six empty phases
      cyc(1'b1, 1'b0, 1'b0, P2);
      expect_obs("load2", 3'd6, P2, 7'd9, 4'b0100, 1, 0, 0, 0);
      ticks(4);
      expect_obs("d_spin", 3'd7, 26'd5, 7'd5, 4'b0101, 1, 0, 0, 0);
      ticks(5);
      expect_obs("done2", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0, P2);
      expect_obs("start_in_done", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, '0);
      expect_obs("still_idle", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);

      // Zero program is ignored
      cyc(1'b1, 1'b0, 1'b0, '0);
      expect_obs("start_zero", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);

      // Reset mid-run in the rinse phase
      cyc(1'b1, 1'b0, 1'b0, P1);
      ticks(32);
      expect_obs("rinse_tail", 3'd5, 26'b000_0000_000_000_000_0001_100_101, 7'd10, 4'b0010, 1, 0, 0, 0);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, '0);
      expect_obs("reset_mid", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, '0);
      expect_obs("after_reset", 3'd0, '0, 7'd0, 4'b0000, 0, 0, 0, 0);

      repeat (2) @(negedge cp);
      #1;
      n_checks++;
      if (exp_q.size() == 0)
         n_pass++;
      else
         $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
